sweep_ctrl: RTL

- Sequencer that drives the step (frequency) and amplitude inputs of the CORDIC sine/cosine generator to produce programmable frequency sweeps (chirps).
- Sits between the register/config interface and the generator. Issues the generator's reset and clock-enable, and holds each frequency for a programmed number of sample strobes.
- Supports single up-sweeps and continuous up/down (triangle) sweeps, with abort and config-error detection.

---
 rtl/sweep_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sweep_ctrl.sv
// Chirp sequencer for the CORDIC generator: ARM pulses gen_reset, then steps f_start..f_stop (triangle if mode=1).
// start@T -> gen_reset T+1..T+2, step valid T+3; no backpressure, timing counts ce_in. Ramp option: SWEEP_AMPL_RAMP_EN.
module sweep_ctrl #(
    parameter int ANGLE_WIDTH = 16,
    parameter int DATA_WIDTH  = 12,
    parameter int DWELL_WIDTH = 16,
    parameter int RAMP_STEP   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce_in,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   mode,
    input  logic [ANGLE_WIDTH-1:0] f_start,
    input  logic [ANGLE_WIDTH-1:0] f_stop,
    input  logic [ANGLE_WIDTH-1:0] f_inc,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic [DATA_WIDTH:0]    ampl_in,
    output logic [ANGLE_WIDTH-1:0] step,
    output logic [DATA_WIDTH:0]    ampl,
    output logic                   gen_ce,
    output logic                   gen_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_UP     = 3'd2;
    localparam logic [2:0] S_DOWN   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
`ifdef SWEEP_AMPL_RAMP_EN
    localparam logic [2:0] S_RAMP_UP = 3'd5;
    localparam logic [2:0] S_RAMP_DN = 3'd6;
    localparam logic [2:0] S_AFTER_ARM = S_RAMP_UP;
    localparam logic [2:0] S_END       = S_RAMP_DN;
    localparam logic [DATA_WIDTH+1:0] LP_RSTEP = (DATA_WIDTH+2)'(RAMP_STEP);
`else
    localparam logic [2:0] S_AFTER_ARM = S_UP;
    localparam logic [2:0] S_END       = S_FINISH;
`endif

    logic [2:0]             r_state;
    logic                   r_arm_cnt;
    logic                   r_cfg_err;
    logic                   r_mode;
    logic [ANGLE_WIDTH-1:0] r_f_start, r_f_stop, r_f_inc, r_cur;
    logic [DWELL_WIDTH-1:0] r_dwell, r_dwell_cnt;
    logic [DATA_WIDTH:0]    r_ampl_tgt;

    logic [ANGLE_WIDTH:0]   w_up_sum, w_dn_diff;
    logic [ANGLE_WIDTH-1:0] w_up_next, w_dn_next;
    logic [DWELL_WIDTH-1:0] w_dwell_last;
    logic                   w_expire, w_cfg_bad, w_at_stop, w_at_start;
    logic [DATA_WIDTH:0]    w_ampl_out;

    // Both directions are computed one bit wider so overflow/underflow saturate cleanly.
    assign w_up_sum   = {1'b0, r_cur} + {1'b0, r_f_inc};
    assign w_up_next  = (w_up_sum > {1'b0, r_f_stop}) ? r_f_stop : w_up_sum[ANGLE_WIDTH-1:0];
    assign w_dn_diff  = {1'b0, r_cur} - {1'b0, r_f_inc};
    assign w_dn_next  = (w_dn_diff[ANGLE_WIDTH] || (w_dn_diff[ANGLE_WIDTH-1:0] < r_f_start))
                        ? r_f_start : w_dn_diff[ANGLE_WIDTH-1:0];
    assign w_at_stop  = (r_cur == r_f_stop);
    assign w_at_start = (r_cur == r_f_start);

    assign w_dwell_last = (r_dwell == '0) ? '0 : r_dwell - DWELL_WIDTH'(1);
    assign w_expire     = ce_in && (r_dwell_cnt == w_dwell_last);
    assign w_cfg_bad    = (f_start > f_stop) || (f_inc == '0);

`ifdef SWEEP_AMPL_RAMP_EN
    logic [DATA_WIDTH:0]   r_ampl;
    logic [DATA_WIDTH+1:0] w_ramp_sum;
    logic [DATA_WIDTH:0]   w_ramp_up, w_ramp_dn;
    assign w_ramp_sum = {1'b0, r_ampl} + LP_RSTEP;
    assign w_ramp_up  = (w_ramp_sum > {1'b0, r_ampl_tgt}) ? r_ampl_tgt : w_ramp_sum[DATA_WIDTH:0];
    assign w_ramp_dn  = ({1'b0, r_ampl} <= LP_RSTEP) ? '0 : r_ampl - LP_RSTEP[DATA_WIDTH:0];
    assign w_ampl_out = r_ampl;
`else
    assign w_ampl_out = r_ampl_tgt;
`endif

    always_comb begin
        step      = '0;
        ampl      = '0;
        gen_ce    = 1'b0;
        gen_reset = 1'b0;
        case (r_state)
            S_ARM: begin
                gen_ce    = 1'b1;
                gen_reset = 1'b1;
            end
            S_UP, S_DOWN: begin
                step   = r_cur;
                ampl   = w_ampl_out;
                gen_ce = ce_in;
            end
`ifdef SWEEP_AMPL_RAMP_EN
            S_RAMP_UP, S_RAMP_DN: begin
                step   = r_cur;
                ampl   = r_ampl;
                gen_ce = ce_in;
            end
`endif
            S_FINISH: begin
                step = r_cur;
                ampl = w_ampl_out;
            end
            default: ;
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_FINISH);
    assign cfg_err = r_cfg_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_arm_cnt   <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_mode      <= 1'b0;
            r_f_start   <= '0;
            r_f_stop    <= '0;
            r_f_inc     <= '0;
            r_cur       <= '0;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
            r_ampl_tgt  <= '0;
`ifdef SWEEP_AMPL_RAMP_EN
            r_ampl      <= '0;
`endif
        end else begin
            r_cfg_err <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_dwell_cnt <= '0;
`ifdef SWEEP_AMPL_RAMP_EN
                r_ampl      <= '0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_f_start  <= f_start;
                            r_f_stop   <= f_stop;
                            r_f_inc    <= f_inc;
                            r_dwell    <= dwell;
                            r_mode     <= mode;
                            r_ampl_tgt <= ampl_in;
                            if (w_cfg_bad) begin
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_state   <= S_ARM;
                                r_arm_cnt <= 1'b0;
                            end
                        end
                    end
                    S_ARM: begin
                        r_arm_cnt <= 1'b1;
                        if (r_arm_cnt) begin
                            r_state     <= S_AFTER_ARM;
                            r_cur       <= r_f_start;
                            r_dwell_cnt <= '0;
                        end
                    end
`ifdef SWEEP_AMPL_RAMP_EN
                    S_RAMP_UP: begin
                        if (ce_in) begin
                            r_ampl <= w_ramp_up;
                            if (w_ramp_up == r_ampl_tgt) r_state <= S_UP;
                        end
                    end
                    S_RAMP_DN: begin
                        if (ce_in) begin
                            r_ampl <= w_ramp_dn;
                            if (w_ramp_dn == '0) r_state <= S_FINISH;
                        end
                    end
`endif
                    S_UP: begin
                        if (w_expire) begin
                            r_dwell_cnt <= '0;
                            if (w_at_stop) begin
                                if (!r_mode || (r_f_start == r_f_stop)) begin
                                    r_state <= S_END;
                                end else begin
                                    r_state <= S_DOWN;
                                    r_cur   <= w_dn_next;
                                end
                            end else begin
                                r_cur <= w_up_next;
                            end
                        end else if (ce_in) begin
                            r_dwell_cnt <= r_dwell_cnt + DWELL_WIDTH'(1);
                        end
                    end
                    S_DOWN: begin
                        if (w_expire) begin
                            r_dwell_cnt <= '0;
                            if (w_at_start) begin
                                r_state <= S_UP;
                                r_cur   <= w_up_next;
                            end else begin
                                r_cur <= w_dn_next;
                            end
                        end else if (ce_in) begin
                            r_dwell_cnt <= r_dwell_cnt + DWELL_WIDTH'(1);
                        end
                    end
                    S_FINISH: r_state <= S_IDLE;
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
